// File: rtl/regfile_2r1w_param.sv
// Two-read/one-write register file. Decodes rs1/rs2/rd from an RV instruction word,
// registers the read data one cycle later, with optional write bypass and hardwired x0.
module regfile_2r1w_param #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     ins,
    input  logic            ins_valid,
    input  logic            reg_write,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] write_data,
    output logic [XLEN-1:0] readData1,
    output logic [XLEN-1:0] readData2,
    output logic [4:0]      rd_q,
    output logic            data_valid,
    output logic            wr_err
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] rdata1_q, rdata1_d;
    logic [XLEN-1:0] rdata2_q, rdata2_d;
    logic [4:0]      rd_idx_q;
    logic            data_valid_q;
    logic            wr_err_q;
    logic            wr_legal;
    logic            unused_ins;

    assign unused_ins = ^{ins[31:25], ins[14:12], ins[6:0]};

    function automatic logic in_range(input logic [4:0] idx);
        return int'(idx) < NREGS;
    endfunction

    assign wr_legal = reg_write && in_range(wr_addr) && !(ZERO_REG != 0 && wr_addr == 5'd0);

    // Range and x0 checks come before the bypass so an illegal write is never forwarded.
    function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx);
        if (!in_range(idx) || (ZERO_REG != 0 && idx == 5'd0)) begin
            return '0;
        end
        if (BYPASS != 0 && wr_legal && wr_addr == idx) begin
            return write_data;
        end
        return regs_q[idx[AW-1:0]];
    endfunction

    assign rdata1_d = read_port(ins[19:15]);
    assign rdata2_d = read_port(ins[24:20]);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            rdata1_q     <= '0;
            rdata2_q     <= '0;
            rd_idx_q     <= '0;
            data_valid_q <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            if (wr_legal) begin
                regs_q[wr_addr[AW-1:0]] <= write_data;
            end
            wr_err_q     <= reg_write && !in_range(wr_addr);
            data_valid_q <= ins_valid;
            if (ins_valid) begin
                rdata1_q <= rdata1_d;
                rdata2_q <= rdata2_d;
                rd_idx_q <= ins[11:7];
            end
        end
    end

    assign readData1  = rdata1_q;
    assign readData2  = rdata2_q;
    assign rd_q       = rd_idx_q;
    assign data_valid = data_valid_q;
    assign wr_err     = wr_err_q;
endmodule
